// File: rtl/eth_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame
// Brief    : Builds preamble/MAC(+VLAN)/IPv4/UDP header from latched metadata
//            and streams header then payload as DATA_W beats with an IFG.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_frame #(
  parameter int          DATA_W       = 16,
  parameter int          KEEP_W       = DATA_W / 8,
  parameter int          LEN_W        = $clog2(KEEP_W + 1),
  parameter int          PKT_LEN_W    = 16,
  parameter bit          VLAN_TAG     = 1'b1,
  parameter bit          UDP_CS       = 1'b0,
  parameter int          IFG_BEATS    = 6,
  parameter logic [47:0] MAC_DST      = 48'h02_00_00_00_00_02,
  parameter logic [47:0] MAC_SRC      = 48'h02_00_00_00_00_01,
  parameter logic [15:0] VLAN_TCI     = 16'h0064,
  parameter logic [31:0] IP_SRC       = 32'hC0A8_0001,
  parameter logic [31:0] IP_DST       = 32'hC0A8_0002,
  parameter logic [15:0] IP_ID        = 16'h0000,
  parameter logic [7:0]  IP_TTL       = 8'd64,
  parameter logic [7:0]  IP_PROTO     = 8'h11,
  parameter logic [15:0] UDP_SRC_PORT = 16'd1234,
  parameter logic [15:0] UDP_DST_PORT = 16'd5678
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 app_valid_i,
  output logic                 app_ready_o,
  input  logic [DATA_W-1:0]    app_data_i,
  input  logic [LEN_W-1:0]     app_len_i,
  input  logic [PKT_LEN_W-1:0] app_pkt_len_i,
  input  logic [15:0]          app_cs_i,
  input  logic                 pma_ready_i,
  output logic                 pma_valid_o,
  output logic [DATA_W-1:0]    pma_data_o,
  output logic [LEN_W-1:0]     pma_len_o,
  output logic                 pma_start_o,
  output logic                 pma_last_o,
  output logic                 busy_o
);

  localparam int c_mac_n      = 14 + 4 * int'(VLAN_TAG);
  localparam int c_head_n     = 8 + c_mac_n + 20 + 8;
  localparam int c_head_bits  = c_head_n * 8;
  localparam int c_head_beats = c_head_n / KEEP_W;
  localparam int c_cnt_w      = 16;
  localparam int c_bcnt_w     = PKT_LEN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2,
    S_IFG  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [DATA_W-1:0]      r_data, w_data_nxt;
  logic [LEN_W-1:0]       r_len, w_len_nxt;
  logic                   r_start, w_start_nxt;
  logic                   r_last, w_last_nxt;
  logic [c_head_bits-1:0] r_shift, w_shift_nxt;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
  logic [PKT_LEN_W-1:0]   r_pkt_len, w_pkt_len_nxt;
  logic [c_bcnt_w-1:0]    r_byte_cnt, w_byte_cnt_nxt;

  logic                   w_adv;
  logic [c_bcnt_w-1:0]    w_sum;
  logic [15:0]            w_ip_len, w_udp_len, w_udp_cs, w_ip_cs, w_fold2;
  logic [19:0]            w_cs_sum;
  logic [16:0]            w_fold1;
  logic [c_mac_n*8-1:0]   w_mac;
  logic [c_head_bits-1:0] w_head;

  // Header fields are derived from the live metadata and captured whole in IDLE.
  assign w_ip_len  = 16'(app_pkt_len_i) + 16'd28;
  assign w_udp_len = 16'(app_pkt_len_i) + 16'd8;
  assign w_udp_cs  = UDP_CS ? app_cs_i : 16'h0000;

  assign w_cs_sum = 20'h04500 + 20'(w_ip_len) + 20'(IP_ID) + 20'h04000
                  + 20'({IP_TTL, IP_PROTO})
                  + 20'(IP_SRC[31:16]) + 20'(IP_SRC[15:0])
                  + 20'(IP_DST[31:16]) + 20'(IP_DST[15:0]);
  assign w_fold1  = 17'(w_cs_sum[15:0]) + 17'(w_cs_sum[19:16]);
  assign w_fold2  = w_fold1[15:0] + 16'(w_fold1[16]);
  assign w_ip_cs  = ~w_fold2;

  generate
    if (VLAN_TAG) begin : g_vlan
      assign w_mac = {MAC_DST, MAC_SRC, 16'h8100, VLAN_TCI, 16'h0800};
    end else begin : g_no_vlan
      assign w_mac = {MAC_DST, MAC_SRC, 16'h0800};
    end
  endgenerate

  assign w_head = {64'h5555_5555_5555_55D5, w_mac,
                   8'h45, 8'h00, w_ip_len, IP_ID, 16'h4000, IP_TTL, IP_PROTO,
                   w_ip_cs, IP_SRC, IP_DST,
                   UDP_SRC_PORT, UDP_DST_PORT, w_udp_len, w_udp_cs};

  assign w_adv = !r_valid || pma_ready_i;
  assign w_sum = r_byte_cnt + c_bcnt_w'(app_len_i);

  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_valid;
    w_data_nxt     = r_data;
    w_len_nxt      = r_len;
    w_start_nxt    = r_start;
    w_last_nxt     = r_last;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_pkt_len_nxt  = r_pkt_len;
    w_byte_cnt_nxt = r_byte_cnt;
    app_ready_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Beat 0 goes straight to the output so start appears one cycle after valid.
        if (app_valid_i && w_adv) begin
          w_valid_nxt    = 1'b1;
          w_data_nxt     = w_head[c_head_bits-1 -: DATA_W];
          w_len_nxt      = LEN_W'(KEEP_W);
          w_start_nxt    = 1'b1;
          w_last_nxt     = 1'b0;
          w_shift_nxt    = w_head << DATA_W;
          w_cnt_nxt      = c_cnt_w'(1);
          w_pkt_len_nxt  = app_pkt_len_i;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = S_HEAD;
        end
      end
      S_HEAD: begin
        if (w_adv) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = r_shift[c_head_bits-1 -: DATA_W];
          w_len_nxt   = LEN_W'(KEEP_W);
          w_start_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_shift_nxt = r_shift << DATA_W;
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(c_head_beats - 1)) begin
            w_cnt_nxt   = '0;
            w_last_nxt  = (r_pkt_len == '0);
            w_state_nxt = (r_pkt_len == '0) ? S_IFG : S_DATA;
          end
        end
      end
      S_DATA: begin
        app_ready_o = w_adv;
        if (w_adv) begin
          w_start_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_valid_nxt = app_valid_i;
          if (app_valid_i) begin
            w_data_nxt     = app_data_i;
            w_len_nxt      = app_len_i;
            w_byte_cnt_nxt = w_sum;
            if (w_sum >= {1'b0, r_pkt_len}) begin
              w_last_nxt  = 1'b1;
              w_len_nxt   = LEN_W'({1'b0, r_pkt_len} - r_byte_cnt);
              w_cnt_nxt   = '0;
              w_state_nxt = S_IFG;
            end
          end
        end
      end
      default: begin
        if (w_adv) begin
          w_valid_nxt = 1'b0;
          w_start_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
        // Gap cycles count only once the final beat has left the output register.
        if (!r_valid) begin
          if (r_cnt == c_cnt_w'(IFG_BEATS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_len      <= '0;
      r_start    <= 1'b0;
      r_last     <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pkt_len  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_data     <= w_data_nxt;
      r_len      <= w_len_nxt;
      r_start    <= w_start_nxt;
      r_last     <= w_last_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pkt_len  <= w_pkt_len_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  assign pma_valid_o = r_valid;
  assign pma_data_o  = r_data;
  assign pma_len_o   = r_len;
  assign pma_start_o = r_start;
  assign pma_last_o  = r_last;
  assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame.sv
`default_nettype none
// Bench for eth_tx_frame: table-driven and randomised frames against a byte-level
// frame model; a second 8-bit, untagged, checksum-enabled instance covers the narrow bus.
module tb_eth_tx_frame;
  localparam int          KW         = 2;
  localparam int          HEAD_BEATS = 27;
  localparam int          IFG        = 6;
  localparam logic [47:0] MAC_DST    = 48'h0A1B_2C3D_4E5F;
  localparam logic [47:0] MAC_SRC    = 48'h0011_2233_4455;
  localparam logic [15:0] VLAN_TCI   = 16'h2005;
  localparam logic [15:0] IP_ID      = 16'h1C46;
  localparam logic [15:0] SPORT      = 16'hC350;
  localparam logic [15:0] DPORT      = 16'h0035;
  localparam logic [31:0] IP_SRC     = 32'h0A00_0001;
  localparam logic [31:0] IP_DST     = 32'h0A00_00FE;
  localparam logic [7:0]  TTL        = 8'h40;
  localparam logic [7:0]  PROTO      = 8'h11;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int    pkt_len;
    int    fix_len;
    int    rmode;
    int    gmode;
    int    exp_beats;
    int    exp_last;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic app_valid = 1'b0, app_ready, pma_ready = 1'b0, pma_valid, pma_start, pma_last, busy;
  logic [15:0] app_data = '0, app_pkt_len = '0, app_cs = '0, pma_data;
  logic [1:0]  app_len = '0, pma_len;
  logic b_app_valid = 1'b0, b_app_ready, b_pma_ready = 1'b0, b_pma_valid, b_pma_start, b_pma_last, b_busy;
  logic [7:0]  b_app_data = '0, b_pma_data;
  logic [0:0]  b_app_len = '0, b_pma_len;
  logic [15:0] b_pkt_len = '0, b_cs = '0;

  int n_vec = 0, n_bad = 0, cyc = 0, prev_last = -1;

  always #5 clk = ~clk;

  eth_tx_frame #(.DATA_W(16), .VLAN_TAG(1'b1), .UDP_CS(1'b0), .IFG_BEATS(IFG),
    .MAC_DST(MAC_DST), .MAC_SRC(MAC_SRC), .VLAN_TCI(VLAN_TCI), .IP_SRC(IP_SRC), .IP_DST(IP_DST),
    .IP_ID(IP_ID), .IP_TTL(TTL), .IP_PROTO(PROTO), .UDP_SRC_PORT(SPORT), .UDP_DST_PORT(DPORT)
  ) dut (
    .clk(clk), .nreset(nreset), .app_valid_i(app_valid), .app_ready_o(app_ready),
    .app_data_i(app_data), .app_len_i(app_len), .app_pkt_len_i(app_pkt_len), .app_cs_i(app_cs),
    .pma_ready_i(pma_ready), .pma_valid_o(pma_valid), .pma_data_o(pma_data), .pma_len_o(pma_len),
    .pma_start_o(pma_start), .pma_last_o(pma_last), .busy_o(busy)
  );

  eth_tx_frame #(.DATA_W(8), .VLAN_TAG(1'b0), .UDP_CS(1'b1), .IFG_BEATS(IFG),
    .MAC_DST(MAC_DST), .MAC_SRC(MAC_SRC), .VLAN_TCI(VLAN_TCI), .IP_SRC(IP_SRC), .IP_DST(IP_DST),
    .IP_ID(IP_ID), .IP_TTL(TTL), .IP_PROTO(PROTO), .UDP_SRC_PORT(SPORT), .UDP_DST_PORT(DPORT)
  ) dut8 (
    .clk(clk), .nreset(nreset), .app_valid_i(b_app_valid), .app_ready_o(b_app_ready),
    .app_data_i(b_app_data), .app_len_i(b_app_len), .app_pkt_len_i(b_pkt_len), .app_cs_i(b_cs),
    .pma_ready_i(b_pma_ready), .pma_valid_o(b_pma_valid), .pma_data_o(b_pma_data), .pma_len_o(b_pma_len),
    .pma_start_o(b_pma_start), .pma_last_o(b_pma_last), .busy_o(b_busy)
  );

  function automatic void chk(input bit ok, input string name, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Expected on-wire header bytes, assembled field by field.
  function automatic void build_hdr(input int pkt_len, input logic [15:0] cs, input bit vlan,
                                    input bit ucs, output bq_t q);
    logic [7:0]  ip[20];
    logic [15:0] ipl, udl, c;
    int          s;
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) q.push_back(MAC_DST[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(MAC_SRC[8*i +: 8]);
    if (vlan) begin
      q.push_back(8'h81); q.push_back(8'h00);
      q.push_back(VLAN_TCI[15:8]); q.push_back(VLAN_TCI[7:0]);
    end
    q.push_back(8'h08); q.push_back(8'h00);
    ipl = 16'(pkt_len + 28);
    udl = 16'(pkt_len + 8);
    ip = '{8'h45, 8'h00, ipl[15:8], ipl[7:0], IP_ID[15:8], IP_ID[7:0], 8'h40, 8'h00, TTL, PROTO,
           8'h00, 8'h00, IP_SRC[31:24], IP_SRC[23:16], IP_SRC[15:8], IP_SRC[7:0],
           IP_DST[31:24], IP_DST[23:16], IP_DST[15:8], IP_DST[7:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s += int'({ip[2*i], ip[2*i+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    c = ~16'(s);
    ip[10] = c[15:8];
    ip[11] = c[7:0];
    for (int i = 0; i < 20; i++) q.push_back(ip[i]);
    q.push_back(SPORT[15:8]); q.push_back(SPORT[7:0]);
    q.push_back(DPORT[15:8]); q.push_back(DPORT[7:0]);
    q.push_back(udl[15:8]);   q.push_back(udl[7:0]);
    q.push_back(ucs ? cs[15:8] : 8'h00);
    q.push_back(ucs ? cs[7:0]  : 8'h00);
  endfunction

  function automatic void cmp_bytes(input bq_t got, input bq_t exp, input string name);
    int m;
    m = -1;
    chk(got.size() == exp.size(), {name, ":byte_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (m < 0 && got[i] != exp[i]) m = i;
    if (m >= 0) chk(1'b0, $sformatf("%s:byte[%0d]", name, m), got[m], exp[m]);
    else        chk(1'b1, {name, ":bytes"}, 0, 0);
  endfunction

  // rmode: 0 ready high, 1 toggling, 2 random. gmode: 0 no gaps, 1 alternate, 2 random.
  task automatic run_frame(input int pkt_len, input int fix_len, input int rmode, input int gmode,
                           input int exp_beats_i, input int exp_last_i, input string name);
    bq_t         exp, got;
    logic [15:0] pd[$];
    int          pl[$];
    int          sum, l, idx, beats, first_v, last_len, exp_beats, exp_last, start_err;
    bit          started, acc, done, saw_rdy, hold_v;
    logic [20:0] held, cur;
    logic [15:0] cs, d;
    cs = 16'($urandom);
    build_hdr(pkt_len, cs, 1'b1, 1'b0, exp);
    sum = 0;
    exp_last = KW;
    while (sum < pkt_len) begin
      l = (fix_len != 0) ? fix_len : int'($urandom_range(1, 2));
      d = 16'($urandom);
      pd.push_back(d);
      pl.push_back(l);
      for (int b = 0; b < l; b++) if (sum + b < pkt_len) exp.push_back(d[15-8*b -: 8]);
      exp_last = pkt_len - sum;
      sum += l;
    end
    exp_beats = (exp_beats_i >= 0) ? exp_beats_i : HEAD_BEATS + pd.size();
    if (exp_last_i >= 0) exp_last = exp_last_i;
    started = 0; done = 0; saw_rdy = 0; hold_v = 0;
    idx = 0; beats = 0; first_v = -1; last_len = -1; start_err = 0; held = '0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      cyc++;
      pma_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
      if (!started) begin
        app_valid   = 1'b1;
        app_data    = (pd.size() > 0) ? pd[0] : 16'($urandom);
        app_len     = (pl.size() > 0) ? 2'(pl[0]) : 2'(KW);
        app_pkt_len = 16'(pkt_len);
        app_cs      = cs;
      end else if (idx < pd.size()) begin
        app_valid = (gmode == 1) ? 1'((cyc % 2) == 0) :
                    (gmode == 2) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        app_data  = pd[idx];
        app_len   = 2'(pl[idx]);
      end else begin
        app_valid = 1'b0;
      end
      #1;
      cur = {pma_data, pma_len, pma_start, pma_last, pma_valid};
      if (hold_v) chk(cur == held, {name, ":stall_hold"}, cur, held);
      hold_v = pma_valid && !pma_ready;
      held   = cur;
      if (app_ready) saw_rdy = 1'b1;
      acc = !started && app_valid && !busy;
      if (started && app_valid && app_ready) idx++;
      if (acc) started = 1'b1;
      if (pma_valid && first_v < 0) first_v = cyc;
      if (pma_valid && pma_ready) begin
        beats++;
        if (pma_start != (beats == 1)) start_err++;
        for (int b = 0; b < int'(pma_len); b++) got.push_back(pma_data[15-8*b -: 8]);
        if (pma_last) begin
          done     = 1'b1;
          last_len = int'(pma_len);
          if (prev_last >= 0)
            chk(first_v - prev_last - 1 == IFG + 1, {name, ":ifg_gap"}, first_v - prev_last - 1, IFG + 1);
          prev_last = cyc;
        end
      end
    end
    chk(done, {name, ":frame_done"}, done, 1);
    chk(beats == exp_beats, {name, ":beats"}, beats, exp_beats);
    chk(last_len == exp_last, {name, ":last_len"}, last_len, exp_last);
    chk(start_err == 0, {name, ":start_flag"}, start_err, 0);
    if (pkt_len == 0) chk(!saw_rdy, {name, ":app_ready"}, saw_rdy, 0);
    if (got.size() > 51) begin
      chk({got[28], got[29]} == 16'(pkt_len + 28), {name, ":ip_len"}, {got[28], got[29]}, 16'(pkt_len + 28));
      chk({got[50], got[51]} == 16'(pkt_len + 8), {name, ":udp_len"}, {got[50], got[51]}, 16'(pkt_len + 8));
    end
    cmp_bytes(got, exp, name);
  endtask

  initial begin
    vec_t        tbl[7];
    bq_t         exp8, got8;
    logic [7:0]  pb[3];
    int          nb, bi;
    bit          hit, started8, done8;

    tbl[0] = '{4, 2, 0, 0, 29, 2, "t1_basic"};
    tbl[1] = '{5, 2, 0, 0, 30, 1, "t2_excess"};
    tbl[2] = '{0, 2, 0, 0, 27, 2, "t3_empty"};
    tbl[3] = '{4, 2, 1, 0, 29, 2, "t4_stall"};
    tbl[4] = '{6, 2, 0, 1, 30, 2, "t5_gaps"};
    tbl[5] = '{3, 1, 2, 2, 30, 1, "single_byte_beats"};
    tbl[6] = '{7, 2, 2, 0, 31, 1, "odd_len"};

    repeat (3) @(negedge clk);
    #1;
    chk({pma_valid, pma_start, pma_last, pma_data, pma_len, app_ready, busy} == '0,
        "reset_outputs", {pma_valid, pma_start, pma_last, pma_data, pma_len, app_ready, busy}, 0);
    chk(b_pma_valid == 1'b0 && b_busy == 1'b0, "reset_outputs8", {b_pma_valid, b_busy}, 0);
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].pkt_len, tbl[i].fix_len, tbl[i].rmode, tbl[i].gmode,
                tbl[i].exp_beats, tbl[i].exp_last, tbl[i].name);

    // Reset asserted in the middle of the header.
    app_valid = 1'b1; app_pkt_len = 16'd8; app_len = 2'd2; app_data = 16'hA5A5;
    nb = 0; hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      pma_ready = 1'b1;
      #1;
      if (pma_valid && pma_ready) nb++;
      if (nb == 10) hit = 1'b1;
    end
    chk(hit, "t6_reach_beat10", nb, 10);
    @(posedge clk);
    #2;
    chk(busy == 1'b1, "t6_busy_before_reset", busy, 1);
    nreset = 1'b0;
    #1;
    chk({pma_valid, pma_start, pma_last, pma_data, pma_len, app_ready, busy} == '0,
        "t6_reset_outputs", {pma_valid, pma_start, pma_last, pma_data, pma_len, app_ready, busy}, 0);
    app_valid = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    #1;
    chk(!busy && !pma_valid, "t6_idle_after_release", {busy, pma_valid}, 0);
    prev_last = -1;
    run_frame(4, 2, 0, 0, 29, 2, "t6_after_reset");

    for (int i = 0; i < 16; i++)
      run_frame(int'($urandom_range(0, 40)), 0, int'($urandom_range(0, 2)), 2, -1, -1, "random");
    @(negedge clk);
    app_valid = 1'b0;

    // Narrow untagged instance with checksum passthrough.
    for (int i = 0; i < 3; i++) pb[i] = 8'($urandom);
    build_hdr(3, 16'hBEEF, 1'b0, 1'b1, exp8);
    for (int i = 0; i < 3; i++) exp8.push_back(pb[i]);
    started8 = 0; done8 = 0; bi = 0; nb = 0;
    for (int k = 0; k < 500 && !done8; k++) begin
      @(negedge clk);
      b_pma_ready = 1'b1;
      b_app_len   = 1'b1;
      b_pkt_len   = 16'd3;
      b_cs        = 16'hBEEF;
      b_app_valid = !started8 || (bi < 3);
      b_app_data  = pb[(bi < 3) ? bi : 2];
      #1;
      if (started8 && b_app_valid && b_app_ready) bi++;
      if (!started8 && b_app_valid && !b_busy) started8 = 1'b1;
      if (b_pma_valid && b_pma_ready) begin
        nb++;
        if (nb == 1) chk(b_pma_start, "t7_start", b_pma_start, 1);
        for (int b = 0; b < int'(b_pma_len); b++) got8.push_back(b_pma_data);
        if (b_pma_last) done8 = 1'b1;
      end
    end
    b_app_valid = 1'b0;
    chk(done8, "t7_frame_done", done8, 1);
    chk(nb == 53, "t7_beats", nb, 53);
    if (got8.size() > 49) begin
      chk(got8[48] == 8'hBE, "t7_cs_hi", got8[48], 8'hBE);
      chk(got8[49] == 8'hEF, "t7_cs_lo", got8[49], 8'hEF);
    end else begin
      chk(1'b0, "t7_cs_present", got8.size(), 50);
    end
    cmp_bytes(got8, exp8, "t7_narrow");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
